seg7_scan_driver: RTL

Multiplexed 4-digit 7-segment display driver that sits directly downstream of the AXI-Lite 7-segment register slave. It consumes the slave's register fields: hex digits, decimal points, digit enables and brightness. It latches them into shadow registers only at frame boundaries, so the display never tears. It then time-multiplexes the digits onto shared segment/anode pins with per-slot PWM dimming.

---
 rtl/seg7_scan_driver.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
// Multiplexed 4-digit 7-segment driver with per-slot PWM dimming.
// Configuration from the register slave is captured into shadow registers
// only at frame boundaries, so a frame is never drawn with mixed settings.
module seg7_scan_driver #(
   parameter int unsigned CLK_DIV    = 100000,
   parameter bit          ACTIVE_LOW = 1'b1
) (
   input  logic        ACLK,
   input  logic        ARESET,
   input  logic [15:0] digit_data,
   input  logic [3:0]  dp_en,
   input  logic [3:0]  digit_en,
   input  logic [3:0]  brightness,
   input  logic        upd_valid,
   output logic        upd_ack,
   output logic [6:0]  seg,
   output logic        dp,
   output logic [3:0]  an,
   output logic        frame_tick
);

   localparam int unsigned PH_DIV = CLK_DIV / 16;
   localparam int          PC_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int          SUB_W  = (PH_DIV > 1) ? $clog2(PH_DIV) : 1;

   localparam logic [PC_W-1:0]  PC_LAST  = PC_W'(CLK_DIV - 1);
   localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(PH_DIV - 1);

   localparam logic [3:0] AN_INV  = {4{ACTIVE_LOW}};
   localparam logic [6:0] SEG_INV = {7{ACTIVE_LOW}};

   // Hex digit to active-high gfedcba segment pattern.
   function automatic logic [6:0] decode(input logic [3:0] value);
      logic [6:0] pattern;
      case (value)
         4'h0: pattern = 7'h3F;
         4'h1: pattern = 7'h06;
         4'h2: pattern = 7'h5B;
         4'h3: pattern = 7'h4F;
         4'h4: pattern = 7'h66;
         4'h5: pattern = 7'h6D;
         4'h6: pattern = 7'h7D;
         4'h7: pattern = 7'h07;
         4'h8: pattern = 7'h7F;
         4'h9: pattern = 7'h6F;
         4'hA: pattern = 7'h77;
         4'hB: pattern = 7'h7C;
         4'hC: pattern = 7'h39;
         4'hD: pattern = 7'h5E;
         4'hE: pattern = 7'h79;
         default: pattern = 7'h71;
      endcase
      return pattern;
   endfunction

   // Timing state: prescaler, sub-phase divider, PWM phase and digit index.
   logic [PC_W-1:0]  pc;
   logic [SUB_W-1:0] sub;
   logic [3:0]       ph;
   logic [1:0]       idx;
   logic             pending;

   // Shadow copies of the configuration that the display actually uses.
   logic [15:0] data_sh;
   logic [3:0]  dp_en_sh;
   logic [3:0]  digit_en_sh;
   logic [3:0]  brightness_sh;

   // Next-state values.
   logic [PC_W-1:0]  pc_n;
   logic [SUB_W-1:0] sub_n;
   logic [3:0]       ph_n;
   logic [1:0]       idx_n;
   logic             pending_n;
   logic [15:0]      data_n;
   logic [3:0]       dp_en_n;
   logic [3:0]       digit_en_n;
   logic [3:0]       brightness_n;
   logic             slot_end;
   logic             boundary;
   logic             load;

   // Pin values decoded from the next state, so the registered pins line up
   // with the counters and shadows in the same cycle.
   logic             lit_n;
   logic [3:0]       an_raw;
   logic [6:0]       seg_raw;
   logic             dp_raw;

   // Counter advance, frame-boundary detection and shadow load decision.
   always_comb begin
      slot_end     = (pc == PC_LAST);
      boundary     = slot_end && (idx == 2'd3);
      load         = boundary && (pending || upd_valid);

      pc_n         = slot_end ? '0 : pc + 1'b1;
      sub_n        = (sub == SUB_LAST) ? '0 : sub + 1'b1;
      ph_n         = (sub == SUB_LAST) ? ph + 4'd1 : ph;
      idx_n        = slot_end ? idx + 2'd1 : idx;

      pending_n    = boundary ? 1'b0 : (pending || upd_valid);

      data_n       = data_sh;
      dp_en_n      = dp_en_sh;
      digit_en_n   = digit_en_sh;
      brightness_n = brightness_sh;
      if (load) begin
         data_n       = digit_data;
         dp_en_n      = dp_en;
         digit_en_n   = digit_en;
         brightness_n = brightness;
      end
   end

   // Display decode for the upcoming cycle: active digit, PWM gate, segments.
   always_comb begin
      lit_n   = digit_en_n[idx_n] && (ph_n <= brightness_n);
      an_raw  = 4'b0000;
      seg_raw = 7'b0000000;
      dp_raw  = 1'b0;
      if (lit_n) begin
         an_raw  = 4'b0001 << idx_n;
         seg_raw = decode(data_n[{idx_n, 2'b00} +: 4]);
         dp_raw  = dp_en_n[idx_n];
      end
   end

   // Counter and shadow registers.
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         pc            <= '0;
         sub           <= '0;
         ph            <= 4'd0;
         idx           <= 2'd0;
         pending       <= 1'b0;
         data_sh       <= 16'h0000;
         dp_en_sh      <= 4'h0;
         digit_en_sh   <= 4'h0;
         brightness_sh <= 4'h0;
      end else begin
         pc            <= pc_n;
         sub           <= sub_n;
         ph            <= ph_n;
         idx           <= idx_n;
         pending       <= pending_n;
         data_sh       <= data_n;
         dp_en_sh      <= dp_en_n;
         digit_en_sh   <= digit_en_n;
         brightness_sh <= brightness_n;
      end
   end

   // Registered pins with polarity applied, plus the boundary pulses.
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         an         <= AN_INV;
         seg        <= SEG_INV;
         dp         <= ACTIVE_LOW;
         upd_ack    <= 1'b0;
         frame_tick <= 1'b0;
      end else begin
         an         <= an_raw ^ AN_INV;
         seg        <= seg_raw ^ SEG_INV;
         dp         <= dp_raw ^ ACTIVE_LOW;
         upd_ack    <= load;
         frame_tick <= boundary;
      end
   end

endmodule
